ps2_host_ctrl: RTL and testbench

PS/2 host-side command controller. It shares the keyboard's open-drain clock/data lines between the device-to-host scan-code path and host-to-device commands such as 0xED (set LEDs), 0xEE (echo) and 0xFF (reset). The block:
- accepts one command byte per handshake and serialises it onto the bus;
- checks the line-level ACK bit and waits for the keyboard's response byte, retrying on 0xFE (resend);
- gates the receiver during transmission and forwards unrelated received bytes upstream.

---
 rtl/ps2_host_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_ps2_host_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_ctrl.sv
// PS/2 host command controller: serialises command bytes onto the open-drain bus,
// checks the line ACK, waits for the device response and retries on resend.
module ps2_host_ctrl #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kclk_i,
    input  logic       kdata_i,
    output logic       kclk_oe,
    output logic       kdata_oe,
    output logic       rx_enable,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    output logic       done,
    output logic [1:0] status,
    output logic       busy,
    output logic       key_valid,
    output logic [7:0] key_data
);

    localparam int unsigned CntW = $clog2(INHIBIT_CYCLES + 2);
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned RetW = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {
        StIdle, StInhibit, StReq, StSend, StLineAck, StWaitResp, StRetry, StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [3:0]      bit_idx_q, bit_idx_d;
    logic [RetW-1:0] retry_q, retry_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [9:0]      frame_q, frame_d;
    logic            kclk_oe_q, kclk_oe_d;
    logic            kdata_oe_q, kdata_oe_d;
    logic            done_q, done_d;
    logic [1:0]      status_q, status_d;
    logic            key_valid_q, key_valid_d;
    logic [7:0]      key_data_q, key_data_d;

    logic kclk_meta_q, kclk_s_q, kclk_prev_q;
    logic kdata_meta_q, kdata_s_q;
    logic fall, tmo_hit;

    // Synchronisers idle high so a reset never produces a phantom falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            kclk_meta_q  <= 1'b1;
            kclk_s_q     <= 1'b1;
            kclk_prev_q  <= 1'b1;
            kdata_meta_q <= 1'b1;
            kdata_s_q    <= 1'b1;
        end else begin
            kclk_meta_q  <= kclk_i;
            kclk_s_q     <= kclk_meta_q;
            kclk_prev_q  <= kclk_s_q;
            kdata_meta_q <= kdata_i;
            kdata_s_q    <= kdata_meta_q;
        end
    end

    assign fall    = kclk_prev_q & ~kclk_s_q;
    assign tmo_hit = (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        bit_idx_d   = bit_idx_q;
        retry_d     = retry_q;
        cmd_d       = cmd_q;
        frame_d     = frame_q;
        kclk_oe_d   = kclk_oe_q;
        kdata_oe_d  = kdata_oe_q;
        done_d      = 1'b0;
        status_d    = status_q;
        key_valid_d = 1'b0;
        key_data_d  = key_data_q;

        unique case (state_q)
            StIdle: begin
                kclk_oe_d  = 1'b0;
                kdata_oe_d = 1'b0;
                if (rx_valid) begin
                    key_valid_d = 1'b1;
                    key_data_d  = rx_data;
                end
                if (cmd_valid) begin
                    cmd_d     = cmd_data;
                    frame_d   = {1'b1, ~^cmd_data, cmd_data};
                    retry_d   = '0;
                    cnt_d     = '0;
                    kclk_oe_d = 1'b1;
                    state_d   = StInhibit;
                end
            end
            StInhibit: begin
                if (cnt_q == CntW'(INHIBIT_CYCLES - 1)) begin
                    cnt_d      = '0;
                    kdata_oe_d = 1'b1;
                    state_d    = StReq;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StReq: begin
                bit_idx_d = '0;
                if (cnt_q == CntW'(1)) begin
                    kclk_oe_d = 1'b0;
                    tmo_d     = '0;
                    state_d   = StSend;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StSend: begin
                tmo_d = tmo_q + 1'b1;
                if (tmo_hit) begin
                    kdata_oe_d = 1'b0;
                    status_d   = 2'b10;
                    done_d     = 1'b1;
                    state_d    = StDone;
                end else if (fall) begin
                    if (bit_idx_q == 4'd10) begin
                        state_d = kdata_s_q ? StRetry : StLineAck;
                    end else begin
                        kdata_oe_d = ~frame_q[bit_idx_q];
                        bit_idx_d  = bit_idx_q + 4'd1;
                    end
                end
            end
            StLineAck: begin
                tmo_d = tmo_q + 1'b1;
                if (rx_valid) begin
                    key_valid_d = 1'b1;
                    key_data_d  = rx_data;
                end
                if (tmo_hit) begin
                    status_d = 2'b10;
                    done_d   = 1'b1;
                    state_d  = StDone;
                end else if (kclk_s_q && kdata_s_q) begin
                    tmo_d   = '0;
                    state_d = StWaitResp;
                end
            end
            StWaitResp: begin
                // A byte arriving on the timeout cycle is handled first.
                if (rx_valid) begin
                    if (rx_data == 8'hFA || (cmd_q == 8'hEE && rx_data == 8'hEE)) begin
                        status_d = 2'b00;
                        done_d   = 1'b1;
                        state_d  = StDone;
                    end else if (rx_data == 8'hFE) begin
                        state_d = StRetry;
                    end else begin
                        key_valid_d = 1'b1;
                        key_data_d  = rx_data;
                    end
                end else if (tmo_hit) begin
                    status_d = 2'b10;
                    done_d   = 1'b1;
                    state_d  = StDone;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StRetry: begin
                if (retry_q < RetW'(MAX_RETRY)) begin
                    retry_d   = retry_q + 1'b1;
                    cnt_d     = '0;
                    kclk_oe_d = 1'b1;
                    state_d   = StInhibit;
                end else begin
                    status_d = 2'b01;
                    done_d   = 1'b1;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (rx_valid) begin
                    key_valid_d = 1'b1;
                    key_data_d  = rx_data;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            tmo_q       <= '0;
            bit_idx_q   <= '0;
            retry_q     <= '0;
            cmd_q       <= '0;
            frame_q     <= '0;
            kclk_oe_q   <= 1'b0;
            kdata_oe_q  <= 1'b0;
            done_q      <= 1'b0;
            status_q    <= 2'b00;
            key_valid_q <= 1'b0;
            key_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            bit_idx_q   <= bit_idx_d;
            retry_q     <= retry_d;
            cmd_q       <= cmd_d;
            frame_q     <= frame_d;
            kclk_oe_q   <= kclk_oe_d;
            kdata_oe_q  <= kdata_oe_d;
            done_q      <= done_d;
            status_q    <= status_d;
            key_valid_q <= key_valid_d;
            key_data_q  <= key_data_d;
        end
    end

    assign kclk_oe   = kclk_oe_q;
    assign kdata_oe  = kdata_oe_q;
    assign done      = done_q;
    assign status    = status_q;
    assign key_valid = key_valid_q;
    assign key_data  = key_data_q;
    assign busy      = (state_q != StIdle);
    assign cmd_ready = (state_q == StIdle) && !rst;
    assign rx_enable = (state_q == StIdle) || (state_q == StLineAck) ||
                       (state_q == StWaitResp) || (state_q == StDone);

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Directed bench for ps2_host_ctrl: a simple device model clocks frames on an
// open-drain bus and response bytes are injected on the rx_* side.
module tb_ps2_host_ctrl;

    localparam int unsigned InhibitCycles = 20;
    localparam int unsigned TimeoutCycles = 500;
    localparam int unsigned MaxRetry      = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       kclk_i, kdata_i;
    logic       kclk_oe, kdata_oe, rx_enable;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_data = 8'h00;
    logic       done;
    logic [1:0] status;
    logic       busy, key_valid;
    logic [7:0] key_data;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    always #5 clk = ~clk;

    assign kclk_i  = dev_clk & ~kclk_oe;
    assign kdata_i = dev_data & ~kdata_oe;

    ps2_host_ctrl #(
        .INHIBIT_CYCLES(InhibitCycles),
        .TIMEOUT_CYCLES(TimeoutCycles),
        .MAX_RETRY     (MaxRetry)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .kclk_i   (kclk_i),
        .kdata_i  (kdata_i),
        .kclk_oe  (kclk_oe),
        .kdata_oe (kdata_oe),
        .rx_enable(rx_enable),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_data (cmd_data),
        .done     (done),
        .status   (status),
        .busy     (busy),
        .key_valid(key_valid),
        .key_data (key_data)
    );

    int   checks = 0;
    int   failures = 0;
    int   inh_cnt = 0;
    int   done_cnt = 0;
    logic kclk_oe_prev = 1'b0;

    // Counts inhibit phases (kclk_oe rising) and done pulses.
    always @(negedge clk) begin
        if (kclk_oe === 1'b1 && kclk_oe_prev !== 1'b1) inh_cnt++;
        kclk_oe_prev = kclk_oe;
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_send(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (kclk_oe === 1'b0 && kdata_oe === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_accept(input logic [7:0] d, input bit with_rx, input logic [7:0] rxb);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("accept_ready", 32'(ok), 1);
        cmd_valid = 1'b1;
        cmd_data  = d;
        if (with_rx) begin
            rx_valid = 1'b1;
            rx_data  = rxb;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        rx_valid  = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic dev_frame(input bit ack_low, output logic [9:0] pat,
                             output logic lat_a, output logic lat_b);
        logic ok;
        pat   = '0;
        lat_a = 1'bx;
        lat_b = 1'bx;
        wait_send(ok);
        chk("send_entry", 32'(ok), 1);
        repeat (8) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11) dev_data = ~ack_low;
            dev_clk = 1'b0;
            repeat (2) @(negedge clk);
            if (k == 1) lat_a = kdata_oe;
            @(negedge clk);
            if (k == 1) lat_b = kdata_oe;
            repeat (3) @(negedge clk);
            if (k <= 10) pat[k-1] = kdata_oe;
            repeat (2) @(negedge clk);
            dev_clk = 1'b1;
            repeat (8) @(negedge clk);
        end
        dev_data = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [9:0] pat;
        logic       la, lb, ok;
        int         n, base, dbase;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        chk("rst_kclk_oe", 32'(kclk_oe), 0);
        chk("rst_kdata_oe", 32'(kdata_oe), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_key_valid", 32'(key_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_status", 32'(status), 0);
        chk("rst_key_data", 32'(key_data), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(cmd_ready), 1);
        chk("post_rst_rx_en", 32'(rx_enable), 1);

        // Send 0xED: timing of inhibit/request, bit pattern, ACK, response 0xFA
        do_accept(8'hED, 1'b0, 8'h00);
        chk("ed_busy", 32'(busy), 1);
        chk("ed_kclk_oe", 32'(kclk_oe), 1);
        chk("ed_kdata_oe_early", 32'(kdata_oe), 0);
        chk("ed_rx_en_inh", 32'(rx_enable), 0);
        n = 0;
        while (kdata_oe !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ed_inhibit_len", 32'(n), InhibitCycles);
        chk("ed_req1_kclk", 32'(kclk_oe), 1);
        @(negedge clk);
        chk("ed_req2_kclk", 32'(kclk_oe), 1);
        @(negedge clk);
        chk("ed_send_kclk", 32'(kclk_oe), 0);
        chk("ed_send_start", 32'(kdata_oe), 1);
        dev_frame(1'b1, pat, la, lb);
        chk("ed_lat_2cyc", 32'(la), 1);
        chk("ed_lat_3cyc", 32'(lb), 0);
        chk("ed_pattern", 32'(pat), 'h012);
        chk("ed_rx_en_wait", 32'(rx_enable), 1);
        send_rx(8'hFA);
        chk("ed_done", 32'(done), 1);
        chk("ed_status", 32'(status), 0);
        @(negedge clk);
        chk("ed_done_pulse", 32'(done), 0);
        chk("ed_idle_busy", 32'(busy), 0);

        // Send 0xFF: two resends then 0xFA; a busy-time cmd_valid must be ignored
        base = inh_cnt;
        do_accept(8'hFF, 1'b0, 8'h00);
        dev_frame(1'b1, pat, la, lb);
        chk("ff_pattern1", 32'(pat), 0);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = 8'h00;
        @(negedge clk);
        cmd_valid = 1'b0;
        send_rx(8'hFE);
        chk("ff_resend_nodone", 32'(done), 0);
        dev_frame(1'b1, pat, la, lb);
        chk("ff_pattern2", 32'(pat), 0);
        send_rx(8'hFE);
        dev_frame(1'b1, pat, la, lb);
        send_rx(8'hFA);
        chk("ff_done", 32'(done), 1);
        chk("ff_status", 32'(status), 0);
        chk("ff_inhibits", 32'(inh_cnt - base), 3);

        // Retry exhaustion: resend always, one attempt line-NACKed instead
        base = inh_cnt;
        do_accept(8'h55, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            dev_frame(i != 1, pat, la, lb);
            if (i != 1) send_rx(8'hFE);
        end
        chk("ex_done_lag", 32'(done), 0);
        @(negedge clk);
        chk("ex_done", 32'(done), 1);
        chk("ex_status", 32'(status), 1);
        chk("ex_inhibits", 32'(inh_cnt - base), 4);

        // Device never clocks: timeout 500 cycles after SEND entry
        do_accept(8'hF4, 1'b0, 8'h00);
        wait_send(ok);
        chk("to_send_entry", 32'(ok), 1);
        n = 0;
        while (done !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("to_cycles", 32'(n), TimeoutCycles);
        chk("to_status", 32'(status), 2);
        chk("to_kclk_oe", 32'(kclk_oe), 0);
        chk("to_kdata_oe", 32'(kdata_oe), 0);

        // Echo 0xEE with an unrelated scan code before the echo
        do_accept(8'hEE, 1'b0, 8'h00);
        dev_frame(1'b1, pat, la, lb);
        chk("ee_pattern", 32'(pat), 'h011);
        send_rx(8'h1C);
        chk("ee_fwd_valid", 32'(key_valid), 1);
        chk("ee_fwd_data", 32'(key_data), 'h1C);
        chk("ee_fwd_nodone", 32'(done), 0);
        send_rx(8'hEE);
        chk("ee_done", 32'(done), 1);
        chk("ee_status", 32'(status), 0);
        chk("ee_echo_nofwd", 32'(key_valid), 0);
        repeat (2) @(negedge clk);
        send_rx(8'h1C);
        chk("idle_fwd_valid", 32'(key_valid), 1);
        chk("idle_fwd_data", 32'(key_data), 'h1C);

        // Byte on the acceptance cycle is forwarded; reset at the 5th fall
        do_accept(8'h0F, 1'b1, 8'h2A);
        chk("acc_fwd_valid", 32'(key_valid), 1);
        chk("acc_fwd_data", 32'(key_data), 'h2A);
        chk("acc_busy", 32'(busy), 1);
        wait_send(ok);
        chk("rs_send_entry", 32'(ok), 1);
        repeat (8) @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            dev_clk = 1'b0;
            repeat (8) @(negedge clk);
            dev_clk = 1'b1;
            repeat (8) @(negedge clk);
        end
        dev_clk = 1'b0;
        repeat (3) @(negedge clk);
        chk("rs_fall5_oe", 32'(kdata_oe), 1);
        dbase = done_cnt;
        rst = 1'b1;
        dev_clk = 1'b1;
        @(negedge clk);
        chk("rs_kclk_oe", 32'(kclk_oe), 0);
        chk("rs_kdata_oe", 32'(kdata_oe), 0);
        chk("rs_ready_in_rst", 32'(cmd_ready), 0);
        chk("rs_busy", 32'(busy), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rs_ready_after", 32'(cmd_ready), 1);
        repeat (20) @(negedge clk);
        chk("rs_no_done", 32'(done_cnt - dbase), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
